// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered image.
// Pending image is filled by the host; the active image swaps only at frame start.
module seg_scan_ctrl #(
  parameter int N_DIGIT = 8,
  parameter int DWELL   = 50000,
  parameter int BLANK   = 500
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [31:0]        wr_value,
  input  logic [7:0]         wr_dot,
  input  logic [7:0]         wr_mask,
  input  logic               lz_blank,
  output logic [3:0]         digit,
  output logic               digitEnable,
  output logic               dot,
  output logic [N_DIGIT-1:0] sel,
  output logic               frame_start
);
  localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [N_DIGIT-1:0]        sel_q, sel_d;
  logic [3:0]                digit_q, digit_d;
  logic                      en_q, en_d, dot_q, dot_d, fs_q, fs_d;

  logic                      pend_full_q;
  logic [N_DIGIT-1:0][3:0]   pend_val_q, act_val_q, img_val;
  logic [N_DIGIT-1:0]        pend_dot_q, pend_mask_q, act_dot_q, act_mask_q;
  logic [N_DIGIT-1:0]        img_dot, img_mask, supp;
  logic                      accept, commit;
  logic                      unused_wr;

  assign unused_wr = ^{wr_value, wr_dot, wr_mask};

  assign wr_ready = !pend_full_q;
  assign accept   = wr_valid && !pend_full_q;
  assign commit   = (state_q == ST_BLANK) && (cnt_q == CW'(BLANK - 1)) &&
                    (idx_q == '0) && pend_full_q;

  // The digit about to be shown must already see the image being committed.
  assign img_val  = commit ? pend_val_q  : act_val_q;
  assign img_dot  = commit ? pend_dot_q  : act_dot_q;
  assign img_mask = commit ? pend_mask_q : act_mask_q;

  for (genvar i = 0; i < N_DIGIT; i++) begin : g_supp
    if (i == 0) begin : g_lsd
      assign supp[i] = 1'b0;
    end else begin : g_hi
      assign supp[i] = lz_blank && ~|img_val[N_DIGIT-1:i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    sel_d   = sel_q;
    digit_d = digit_q;
    en_d    = en_q;
    dot_d   = dot_q;
    fs_d    = 1'b0;
    unique case (state_q)
      ST_BLANK: if (cnt_q == CW'(BLANK - 1)) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
        sel_d   = ~(N_DIGIT'(1) << idx_q);
        digit_d = img_val[idx_q];
        dot_d   = img_dot[idx_q];
        en_d    = img_mask[idx_q] && !supp[idx_q];
        fs_d    = (idx_q == '0);
      end
      ST_SHOW: if (cnt_q == CW'(DWELL - 1)) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = (idx_q == IW'(N_DIGIT - 1)) ? '0 : idx_q + IW'(1);
        sel_d   = '1;
        en_d    = 1'b0;
        dot_d   = 1'b0;
      end
      default: state_d = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '1;
      digit_q <= '0;
      en_q    <= 1'b0;
      dot_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      digit_q <= digit_d;
      en_q    <= en_d;
      dot_q   <= dot_d;
      fs_q    <= fs_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_full_q <= 1'b0;
      pend_val_q  <= '0;
      pend_dot_q  <= '0;
      pend_mask_q <= '0;
      act_val_q   <= '0;
      act_dot_q   <= '0;
      act_mask_q  <= '0;
    end else if (commit) begin
      pend_full_q <= 1'b0;
      act_val_q   <= pend_val_q;
      act_dot_q   <= pend_dot_q;
      act_mask_q  <= pend_mask_q;
    end else if (accept) begin
      pend_full_q <= 1'b1;
      pend_val_q  <= wr_value[4*N_DIGIT-1:0];
      pend_dot_q  <= wr_dot[N_DIGIT-1:0];
      pend_mask_q <= wr_mask[N_DIGIT-1:0];
    end
  end

  assign sel         = sel_q;
  assign digit       = digit_q;
  assign digitEnable = en_q;
  assign dot         = dot_q;
  assign frame_start = fs_q;
endmodule
